// File: rtl/uart_tx_queue.sv
// rtl/uart_tx_queue.sv - byte FIFO and launch sequencer feeding the UART transmitter
//
// Purpose: buffers host bytes in a 2**DEPTH_LOG2 deep FIFO. Each byte is handed to
// the transmitter as a registered byte plus a one-cycle strobe. The transmitter's
// idle/done level paces the launches.
//
// Optional feature: define UART_TXQ_OVF_EN to add the sticky overflow flag
// (ovf_stickyH) and its clear input (ovf_clrH).
//
// Ports:
//   sys_clk      in   clock, rising edge
//   sys_rst_l    in   asynchronous active-low reset
//   wr_validH    in   host offers wr_dataH
//   wr_dataH     in   byte to queue
//   wr_readyH    out  queue not full
//   xmitH        out  one-cycle launch strobe
//   xmit_dataH   out  byte presented to the transmitter, held until the next pop
//   xmit_doneH   in   transmitter idle level (low while a frame is in flight)
//   ovf_stickyH  out  sticky dropped-write flag (UART_TXQ_OVF_EN only)
//   ovf_clrH     in   clears ovf_stickyH (UART_TXQ_OVF_EN only)
//   txq_countH   out  queued bytes, excluding the byte in flight
//   txq_idleH    out  queue empty and sequencer idle
module uart_tx_queue #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_l,
  input  logic                  wr_validH,
  input  logic [7:0]            wr_dataH,
  output logic                  wr_readyH,
  output logic                  xmitH,
  output logic [7:0]            xmit_dataH,
  input  logic                  xmit_doneH,
`ifdef UART_TXQ_OVF_EN
  output logic                  ovf_stickyH,
  input  logic                  ovf_clrH,
`endif
  output logic [DEPTH_LOG2:0]   txq_countH,
  output logic                  txq_idleH
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t                state;
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic [1:0]            busy_cnt;
  logic                  push;
  logic                  pop;

  // Readiness looks only at the count, so a full queue refuses a write even
  // when a pop frees a slot on the same edge.
  assign wr_readyH  = (count != FULL_COUNT);
  assign push       = wr_validH & wr_readyH;
  assign pop        = (state == IDLE) & (count != '0) & xmit_doneH;
  assign txq_countH = count;
  assign txq_idleH  = (count == '0) & (state == IDLE);

  always_ff @(posedge sys_clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_dataH;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (DEPTH_LOG2 + 1)'(1);
        2'b01:   count <= count - (DEPTH_LOG2 + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Sequencer. xmitH is high only while in LAUNCH. xmit_dataH changes only on a pop.
  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      state      <= IDLE;
      xmitH      <= 1'b0;
      xmit_dataH <= 8'h00;
      busy_cnt   <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            state      <= LAUNCH;
            xmitH      <= 1'b1;
            xmit_dataH <= mem[rd_ptr];
          end
        end
        LAUNCH: begin
          state    <= WAIT_BUSY;
          xmitH    <= 1'b0;
          busy_cnt <= 2'd0;
        end
        WAIT_BUSY: begin
          // If the transmitter never goes busy, the byte is treated as consumed
          // after 4 idle cycles. It is not relaunched.
          if (!xmit_doneH) begin
            state <= WAIT_DONE;
          end else if (busy_cnt == 2'd3) begin
            state <= IDLE;
          end else begin
            busy_cnt <= busy_cnt + 2'd1;
          end
        end
        WAIT_DONE: begin
          if (xmit_doneH) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          xmitH <= 1'b0;
        end
      endcase
    end
  end

`ifdef UART_TXQ_OVF_EN
  // When a set and a clear occur on the same edge, the set takes priority.
  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      ovf_stickyH <= 1'b0;
    end else if (wr_validH & ~wr_readyH) begin
      ovf_stickyH <= 1'b1;
    end else if (ovf_clrH) begin
      ovf_stickyH <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// tb/tb_uart_tx_queue.sv - directed self-checking bench for uart_tx_queue
module tb_uart_tx_queue;

  localparam int DL      = 3;
  localparam int BIT_CYC = 2;

  logic          sys_clk   = 1'b0;
  logic          sys_rst_l = 1'b0;
  logic          wr_validH = 1'b0;
  logic [7:0]    wr_dataH  = 8'h00;
  logic          wr_readyH;
  logic          xmitH;
  logic [7:0]    xmit_dataH;
  logic          xmit_doneH;
  logic [DL:0]   txq_countH;
  logic          txq_idleH;
`ifdef UART_TXQ_OVF_EN
  logic          ovf_stickyH;
  logic          ovf_clrH = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  // Transmitter model: 0 = responsive UART, 1 = done tied high, 2 = done held low.
  int          tx_mode    = 0;
  logic        model_done = 1'b1;
  logic        tx_line    = 1'b1;
  logic        busy       = 1'b0;
  logic [9:0]  frame      = 10'h3ff;
  int          cyc        = 0;
  int          bitidx     = 0;
  logic [7:0]  sent [$];

  assign xmit_doneH = (tx_mode == 1) ? 1'b1 : (tx_mode == 2) ? 1'b0 : model_done;

  uart_tx_queue #(.DEPTH_LOG2(DL)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_l  (sys_rst_l),
    .wr_validH  (wr_validH),
    .wr_dataH   (wr_dataH),
    .wr_readyH  (wr_readyH),
    .xmitH      (xmitH),
    .xmit_dataH (xmit_dataH),
    .xmit_doneH (xmit_doneH),
`ifdef UART_TXQ_OVF_EN
    .ovf_stickyH(ovf_stickyH),
    .ovf_clrH   (ovf_clrH),
`endif
    .txq_countH (txq_countH),
    .txq_idleH  (txq_idleH)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) begin
    if (busy) begin
      if (cyc == BIT_CYC - 1) begin
        cyc <= 0;
        if (bitidx == 9) begin
          busy       <= 1'b0;
          model_done <= 1'b1;
          tx_line    <= 1'b1;
        end else begin
          bitidx  <= bitidx + 1;
          tx_line <= frame[bitidx + 1];
        end
      end else begin
        cyc <= cyc + 1;
      end
    end else if (xmitH && tx_mode == 0) begin
      busy       <= 1'b1;
      model_done <= 1'b0;
      frame      <= {1'b1, xmit_dataH, 1'b0};
      tx_line    <= 1'b0;
      cyc        <= 0;
      bitidx     <= 0;
      sent.push_back(xmit_dataH);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called at a negedge. Returns at the negedge after the accepting edge.
  task automatic write_byte(input logic [7:0] b);
    int n = 0;
    while (!wr_readyH && n < 200) begin
      @(negedge sys_clk);
      n++;
    end
    checks++;
    if (wr_readyH !== 1'b1) begin
      errors++;
      $display("FAIL write_ready_timeout: ready=%b required 1", wr_readyH);
    end
    wr_validH = 1'b1;
    wr_dataH  = b;
    @(negedge sys_clk);
    wr_validH = 1'b0;
  endtask

  task automatic wait_sent(input int n);
    int k = 0;
    while (sent.size() < n && k < 3000) begin
      @(negedge sys_clk);
      k++;
    end
    checks++;
    if (sent.size() < n) begin
      errors++;
      $display("FAIL wait_sent_timeout: sent=%0d required %0d", sent.size(), n);
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    while (!(txq_idleH && xmit_doneH && !busy) && k < 500) begin
      @(negedge sys_clk);
      k++;
    end
    checks++;
    if (txq_idleH !== 1'b1) begin
      errors++;
      $display("FAIL wait_idle_timeout: idle=%b required 1", txq_idleH);
    end
  endtask

  task automatic test_reset();
    checks += 5;
    if (xmitH !== 1'b0)        begin errors++; $display("FAIL reset_xmit: got %b required 0", xmitH); end
    if (xmit_dataH !== 8'h00)  begin errors++; $display("FAIL reset_data: got %h required 00", xmit_dataH); end
    if (wr_readyH !== 1'b1)    begin errors++; $display("FAIL reset_ready: got %b required 1", wr_readyH); end
    if (txq_countH !== 4'd0)   begin errors++; $display("FAIL reset_count: got %0d required 0", txq_countH); end
    if (txq_idleH !== 1'b1)    begin errors++; $display("FAIL reset_idle: got %b required 1", txq_idleH); end
`ifdef UART_TXQ_OVF_EN
    checks++;
    if (ovf_stickyH !== 1'b0)  begin errors++; $display("FAIL reset_ovf: got %b required 0", ovf_stickyH); end
`endif
  endtask

  task automatic test_single();
    logic [9:0] rx;
    logic [9:0] exp_frame;
    tx_mode = 0;
    sent.delete();
    exp_frame = {1'b1, 8'hA5, 1'b0};
    write_byte(8'hA5);
    checks += 2;
    if (txq_countH !== 4'd1) begin errors++; $display("FAIL single_count_e0: got %0d required 1", txq_countH); end
    if (xmitH !== 1'b0)      begin errors++; $display("FAIL single_xmit_e0: got %b required 0", xmitH); end
    @(negedge sys_clk);
    checks += 3;
    if (xmitH !== 1'b1)        begin errors++; $display("FAIL single_xmit_e1: got %b required 1", xmitH); end
    if (xmit_dataH !== 8'hA5)  begin errors++; $display("FAIL single_data_e1: got %h required a5", xmit_dataH); end
    if (txq_countH !== 4'd0)   begin errors++; $display("FAIL single_count_e1: got %0d required 0", txq_countH); end
    for (int k = 0; k < 10; k++) begin
      @(negedge sys_clk);
      if (k == 0) begin
        checks++;
        if (xmitH !== 1'b0) begin errors++; $display("FAIL single_xmit_e2: got %b required 0", xmitH); end
      end
      rx[k] = tx_line;
      @(negedge sys_clk);
    end
    checks++;
    if (rx !== exp_frame) begin errors++; $display("FAIL single_serial: got %b required %b", rx, exp_frame); end
    wait_idle();
    checks += 2;
    if (txq_idleH !== 1'b1) begin errors++; $display("FAIL single_idle: got %b required 1", txq_idleH); end
    if (sent.size() != 1)   begin errors++; $display("FAIL single_frames: got %0d required 1", sent.size()); end
  endtask

  task automatic test_reset_mid_burst();
    int pulses = 0;
    tx_mode = 0;
    sent.delete();
    for (int i = 0; i < 4; i++) write_byte(8'h31 + 8'(i));
    checks++;
    if (txq_countH !== 4'd3) begin errors++; $display("FAIL midrst_pre_count: got %0d required 3", txq_countH); end
    #2 sys_rst_l = 1'b0;
    #1;
    checks += 4;
    if (txq_countH !== 4'd0)  begin errors++; $display("FAIL midrst_count: got %0d required 0", txq_countH); end
    if (xmitH !== 1'b0)       begin errors++; $display("FAIL midrst_xmit: got %b required 0", xmitH); end
    if (xmit_dataH !== 8'h00) begin errors++; $display("FAIL midrst_data: got %h required 00", xmit_dataH); end
    if (txq_idleH !== 1'b1)   begin errors++; $display("FAIL midrst_idle: got %b required 1", txq_idleH); end
    @(negedge sys_clk);
    sys_rst_l = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge sys_clk);
      if (xmitH) pulses++;
    end
    checks += 2;
    if (pulses != 0)         begin errors++; $display("FAIL midrst_launch: got %0d pulses required 0", pulses); end
    if (txq_countH !== 4'd0) begin errors++; $display("FAIL midrst_post_count: got %0d required 0", txq_countH); end
    wait_idle();
  endtask

  task automatic test_unresponsive();
    int pulses = 0;
    int first_idle = -1;
    tx_mode = 1;
    sent.delete();
    write_byte(8'h3C);
    for (int i = 1; i <= 12; i++) begin
      @(negedge sys_clk);
      if (xmitH) begin
        pulses++;
        checks++;
        if (xmit_dataH !== 8'h3C) begin errors++; $display("FAIL unresp_data: got %h required 3c", xmit_dataH); end
      end
      if (txq_idleH && first_idle < 0) first_idle = i;
    end
    checks += 3;
    if (pulses != 1)         begin errors++; $display("FAIL unresp_pulses: got %0d required 1", pulses); end
    if (first_idle != 6)     begin errors++; $display("FAIL unresp_idle_cycle: got %0d required 6", first_idle); end
    if (txq_countH !== 4'd0) begin errors++; $display("FAIL unresp_count: got %0d required 0", txq_countH); end
    tx_mode = 0;
  endtask

  task automatic test_fill();
    tx_mode = 2;
    sent.delete();
    for (int i = 1; i <= 8; i++) write_byte(8'(i));
    checks += 2;
    if (txq_countH !== 4'd8) begin errors++; $display("FAIL fill_count: got %0d required 8", txq_countH); end
    if (wr_readyH !== 1'b0)  begin errors++; $display("FAIL fill_ready: got %b required 0", wr_readyH); end
    wr_validH = 1'b1;
    wr_dataH  = 8'hFF;
    @(negedge sys_clk);
    wr_validH = 1'b0;
    checks++;
    if (txq_countH !== 4'd8) begin errors++; $display("FAIL fill_drop_count: got %0d required 8", txq_countH); end
`ifdef UART_TXQ_OVF_EN
    checks++;
    if (ovf_stickyH !== 1'b1) begin errors++; $display("FAIL fill_ovf: got %b required 1", ovf_stickyH); end
    ovf_clrH = 1'b1;
    @(negedge sys_clk);
    ovf_clrH = 1'b0;
`endif
    tx_mode = 0;
    wait_sent(8);
    wait_idle();
    checks++;
    if (sent.size() != 8) begin errors++; $display("FAIL fill_frames: got %0d required 8", sent.size()); end
    for (int i = 0; i < 8 && i < sent.size(); i++) begin
      checks++;
      if (sent[i] !== 8'(i + 1)) begin errors++; $display("FAIL fill_order[%0d]: got %h required %h", i, sent[i], 8'(i + 1)); end
    end
  endtask

  task automatic test_wrap();
    tx_mode = 2;
    sent.delete();
    for (int i = 0; i < 6; i++) write_byte(8'h40 + 8'(i));
    tx_mode = 0;
    wait_sent(5);
    for (int i = 6; i < 12; i++) write_byte(8'h40 + 8'(i));
    wait_sent(12);
    wait_idle();
    checks++;
    if (sent.size() != 12) begin errors++; $display("FAIL wrap_frames: got %0d required 12", sent.size()); end
    for (int i = 0; i < 12 && i < sent.size(); i++) begin
      checks++;
      if (sent[i] !== 8'h40 + 8'(i)) begin errors++; $display("FAIL wrap_order[%0d]: got %h required %h", i, sent[i], 8'h40 + 8'(i)); end
    end
  endtask

  task automatic test_simultaneous();
    tx_mode = 2;
    sent.delete();
    for (int i = 0; i < 3; i++) write_byte(8'h21 + 8'(i));
    tx_mode   = 0;
    wr_validH = 1'b1;
    wr_dataH  = 8'h24;
    @(negedge sys_clk);
    wr_validH = 1'b0;
    checks += 3;
    if (txq_countH !== 4'd3)  begin errors++; $display("FAIL simul_count: got %0d required 3", txq_countH); end
    if (xmitH !== 1'b1)       begin errors++; $display("FAIL simul_xmit: got %b required 1", xmitH); end
    if (xmit_dataH !== 8'h21) begin errors++; $display("FAIL simul_data: got %h required 21", xmit_dataH); end
    wait_sent(4);
    wait_idle();
    for (int i = 0; i < 4 && i < sent.size(); i++) begin
      checks++;
      if (sent[i] !== 8'h21 + 8'(i)) begin errors++; $display("FAIL simul_order[%0d]: got %h required %h", i, sent[i], 8'h21 + 8'(i)); end
    end
  endtask

  initial begin
    repeat (3) @(negedge sys_clk);
    sys_rst_l = 1'b1;
    @(negedge sys_clk);
    test_reset();
    test_single();
    test_reset_mid_burst();
    test_unresponsive();
    test_fill();
    test_wrap();
    test_simultaneous();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
